// File: rtl/el2_lsu_trigger_resp_if.sv
// Signal bundle between the LSU trigger-response block and its surroundings.
// slave = the response block, master = the pipeline/debug side driving it.
interface el2_lsu_trigger_resp_if;
  // M-stage trigger compare and pipeline control
  logic [3:0] lsu_trigger_match_m;
  logic       lsu_valid_m;
  logic       flush_m;
  logic       flush_r;

  // Trigger configuration and debug unit handshake
  logic [1:0] trigger_chain;
  logic [3:0] trigger_action;
  logic [3:0] trigger_hit_clr;
  logic       dbg_halt_ack;

  // Responses
  logic [3:0] lsu_trigger_match_r;
  logic       lsu_trigger_exc_r;
  logic       lsu_trigger_halt_req;
  logic [3:0] lsu_trigger_hit;

  // Debug view of the halt FSM: 0 = IDLE, 1 = HALT_PEND
  logic       trig_fsm_state;

  modport slave (
    input  lsu_trigger_match_m,
    input  lsu_valid_m,
    input  flush_m,
    input  flush_r,
    input  trigger_chain,
    input  trigger_action,
    input  trigger_hit_clr,
    input  dbg_halt_ack,
    output lsu_trigger_match_r,
    output lsu_trigger_exc_r,
    output lsu_trigger_halt_req,
    output lsu_trigger_hit,
    output trig_fsm_state
  );

  modport master (
    output lsu_trigger_match_m,
    output lsu_valid_m,
    output flush_m,
    output flush_r,
    output trigger_chain,
    output trigger_action,
    output trigger_hit_clr,
    output dbg_halt_ack,
    input  lsu_trigger_match_r,
    input  lsu_trigger_exc_r,
    input  lsu_trigger_halt_req,
    input  lsu_trigger_hit,
    input  trig_fsm_state
  );
endinterface

// File: rtl/el2_lsu_trigger_resp.sv
// LSU trigger response: chain qualification, M->R match register, sticky hits,
// breakpoint exception and held debug-halt request. Chaining needs LSU_TRIGGER_CHAIN_EN.
module el2_lsu_trigger_resp (
  input  logic                           clk,
  input  logic                           rst,
  el2_lsu_trigger_resp_if.slave          bus
);

  typedef enum logic {
    IDLE      = 1'b0,
    HALT_PEND = 1'b1
  } state_t;

  state_t     r_state;
  logic       r_halt_req;
  logic [3:0] r_match_r;
  logic [3:0] r_hit;

  logic [3:0] w_match_qual_m;
  logic [3:0] w_fire_r;
  logic       w_halt_fire;
  logic       w_exc_fire;

  // A chained pair reports on both triggers only when both raw matches hit.
`ifdef LSU_TRIGGER_CHAIN_EN
  always_comb begin
    w_match_qual_m = bus.lsu_trigger_match_m;
    if (bus.trigger_chain[0]) begin
      w_match_qual_m[1:0] = {2{&bus.lsu_trigger_match_m[1:0]}};
    end
    if (bus.trigger_chain[1]) begin
      w_match_qual_m[3:2] = {2{&bus.lsu_trigger_match_m[3:2]}};
    end
  end
`else
  assign w_match_qual_m = bus.lsu_trigger_match_m;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_match_r <= 4'b0000;
    end else if (bus.lsu_valid_m && !bus.flush_m) begin
      r_match_r <= w_match_qual_m;
    end else begin
      r_match_r <= 4'b0000;
    end
  end

  assign w_fire_r    = r_match_r & ~{4{bus.flush_r}};
  assign w_halt_fire = |(w_fire_r & bus.trigger_action);
  assign w_exc_fire  = |(w_fire_r & ~bus.trigger_action);

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit <= 4'b0000;
    end else begin
      r_hit <= (r_hit & ~bus.trigger_hit_clr) | w_fire_r;
    end
  end

  // Ack in HALT_PEND wins over a coincident halt fire, which is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_halt_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_halt_fire) begin
            r_state    <= HALT_PEND;
            r_halt_req <= 1'b1;
          end
        end
        HALT_PEND: begin
          if (bus.dbg_halt_ack) begin
            r_state    <= IDLE;
            r_halt_req <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_halt_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lsu_trigger_match_r  = r_match_r;
  assign bus.lsu_trigger_hit      = r_hit;
  assign bus.lsu_trigger_halt_req = r_halt_req;
  assign bus.lsu_trigger_exc_r    = (r_state == IDLE) && w_exc_fire && !w_halt_fire;
  assign bus.trig_fsm_state       = r_state;

endmodule

// File: doc/el2_lsu_trigger_resp.md
EL2_LSU_TRIGGER_RESP -- requirements
Module: el2_lsu_trigger_resp

Interface
REQ-001 The block SHALL have no parameters; the trigger count is fixed at 4, arranged as chain pairs {0,1} and {2,3}.
REQ-002 clk  input  1  single block clock; all state is on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 lsu_trigger_match_m  input  4  raw per-trigger match from the M-stage trigger compare.
REQ-005 lsu_valid_m  input  1  M-stage LSU op valid (non-DMA).
REQ-006 flush_m  input  1  kill the M-stage op.
REQ-007 flush_r  input  1  kill the R-stage op.
REQ-008 trigger_chain  input  2  chain enable: bit0 chains 0->1, bit1 chains 2->3.
REQ-009 trigger_action  input  4  per trigger: 1 = enter debug halt, 0 = breakpoint exception.
REQ-010 trigger_hit_clr  input  4  per-trigger clear of the sticky hit bit (tdata1 write).
REQ-011 dbg_halt_ack  input  1  debug unit accepts the halt request.
REQ-012 lsu_trigger_match_r  output  4  registered, chain-qualified match.
REQ-013 lsu_trigger_exc_r  output  1  breakpoint exception request in R.
REQ-014 lsu_trigger_halt_req  output  1  held debug-halt request.
REQ-015 lsu_trigger_hit  output  4  sticky hit bits.

Function
REQ-016 Chain qualification in M: chain[k] set -> both triggers of the pair SHALL report only when both raw matches are 1; chain[k] clear -> each trigger SHALL report independently.
REQ-017 The M->R register SHALL load the qualified match when lsu_valid_m & ~flush_m, and SHALL load 0 otherwise; latency is 1 cycle.
REQ-018 fire_r SHALL equal lsu_trigger_match_r & ~flush_r.
REQ-019 Hit bits: set on the cycle after fire_r[i]=1; clear on the cycle after trigger_hit_clr[i]=1; when set and clear occur in the same cycle, set SHALL win.
REQ-020 FSM states: IDLE and HALT_PEND.
REQ-021 IDLE -> HALT_PEND when |(fire_r & trigger_action).
REQ-022 HALT_PEND -> IDLE when dbg_halt_ack=1.
REQ-023 lsu_trigger_halt_req SHALL be 1 exactly while in HALT_PEND; it rises 1 cycle after the fire and is held until ack.
REQ-024 lsu_trigger_exc_r SHALL be combinational: |(fire_r & ~trigger_action) in IDLE, and only when no halt-action trigger fires in the same cycle (halt has priority).
REQ-025 In HALT_PEND, new fires SHALL update hit bits but SHALL generate no exc and no additional halt.
REQ-026 dbg_halt_ack together with a new halt fire in HALT_PEND SHALL return the FSM to IDLE; that fire is dropped.
REQ-027 dbg_halt_ack in IDLE SHALL be ignored.

Reset
REQ-028 rst SHALL asynchronously clear the M->R register, all hit bits and lsu_trigger_halt_req, and place the FSM in IDLE; lsu_trigger_exc_r is then 0.
REQ-029 rst asserted in HALT_PEND SHALL drop the pending halt with no ack required.

Configuration
REQ-030 Macro LSU_TRIGGER_CHAIN_EN defined: chaining per REQ-016.
REQ-031 Macro LSU_TRIGGER_CHAIN_EN undefined: trigger_chain SHALL be ignored, every trigger SHALL be independent, and all other behaviour is unchanged.

Verification
REQ-032 Independent exception: match_m=0001, valid=1, action=0000, chain=00 -> next cycle match_r=0001 and exc_r=1; hit=0001 one cycle later.
REQ-033 Chained pair: chain=01, match_m=0001 -> match_r=0000; match_m=0011 -> match_r=0011 (with macro defined); without the macro, match_m=0001 -> match_r=0001.
REQ-034 Halt handshake: match_m=0100, action=0100 -> halt_req=1 two cycles later; ack held low 5 cycles -> halt_req stays 1; ack=1 -> halt_req=0 on the next cycle; exc_r never 1.
REQ-035 Flush: match_m=1000 with flush_m=1 -> match_r=0000; next op with flush_r=1 in R -> no hit, exc or halt.
REQ-036 Set/clear collision: hit[2]=1, then fire_r[2]=1 with hit_clr[2]=1 in the same cycle -> hit[2] stays 1; clr alone -> hit[2]=0.
REQ-037 Reset mid-halt: HALT_PEND with hit=0101, assert rst -> halt_req=0, hit=0000, FSM IDLE immediately, without waiting for a clock edge.
